// File: rtl/spectrum_binner_pkg.sv
// Shared definitions for the spectrum binner: FSM state encoding and a
// constant-evaluable ceil(log2) helper used for derived widths.
package spectrum_binner_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PUBLISH = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if (v > (32'd1 << i)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/height_scaler.sv
// Combinational conversion of an averaged group magnitude into a column
// height: linear or log2 scaling, clamp to the matrix, optional peak-hold decay.
module height_scaler
    import spectrum_binner_pkg::*;
#(
    parameter int unsigned BIN_WIDTH   = 24,
    parameter int unsigned MTRX_HEIGHT = 32,
    parameter int unsigned HEIGHT_BITS = 6,
    parameter int unsigned LIN_SHIFT   = 16
) (
    input  logic [BIN_WIDTH-1:0]   avg_i,
    input  logic                   log_mode_i,
    input  logic                   decay_en_i,
    input  logic [HEIGHT_BITS-1:0] prev_i,
    output logic [HEIGHT_BITS-1:0] height_o
);

    localparam logic [BIN_WIDTH-1:0] CAP = BIN_WIDTH'(MTRX_HEIGHT);

    logic [BIN_WIDTH-1:0] lin_w;
    logic [BIN_WIDTH-1:0] log_w;
    logic [BIN_WIDTH-1:0] new_w;
    logic [BIN_WIDTH-1:0] dec_w;

    always_comb begin
        lin_w = avg_i >> LIN_SHIFT;
        if (lin_w > CAP) lin_w = CAP;

        // Log height is the position of the highest set bit plus one.
        log_w = '0;
        for (int unsigned k = 0; k < BIN_WIDTH; k++) begin
            if (avg_i[k]) log_w = BIN_WIDTH'(k + 1);
        end
        if (log_w > CAP) log_w = CAP;

        new_w = log_mode_i ? log_w : lin_w;
        dec_w = (prev_i == '0) ? '0 : BIN_WIDTH'(prev_i) - BIN_WIDTH'(1);
        height_o = HEIGHT_BITS'((decay_en_i && (dec_w > new_w)) ? dec_w : new_w);
    end

endmodule

// File: rtl/spectrum_binner.sv
// Bins a streamed FFT magnitude frame into NUM_COLS column heights held in
// a double-buffered bank; the display bank is read back with 1-cycle latency.
module spectrum_binner
    import spectrum_binner_pkg::*;
#(
    parameter int unsigned BIN_WIDTH   = 24,
    parameter int unsigned NUM_BINS    = 256,
    parameter int unsigned NUM_COLS    = 64,
    parameter int unsigned MTRX_HEIGHT = 32,
    parameter int unsigned HEIGHT_BITS = 6,
    parameter int unsigned LIN_SHIFT   = 16
) (
    input  logic                       MCLK,
    input  logic                       RESET,
    input  logic                       source_valid,
    input  logic                       source_sop,
    input  logic [BIN_WIDTH-1:0]       F_BIN_IN,
    output logic                       sink_ready,
    input  logic                       log_mode,
    input  logic                       decay_en,
    input  logic [clog2(NUM_COLS)-1:0] rd_col,
    output logic [HEIGHT_BITS-1:0]     rd_height,
    output logic                       frame_done
);

    localparam int unsigned GROUP = NUM_BINS / NUM_COLS;
    localparam int unsigned GSH   = clog2(GROUP);
    localparam int unsigned ACC_W = BIN_WIDTH + GSH;
    localparam int unsigned IDX_W = clog2(NUM_BINS);
    localparam int unsigned COL_W = clog2(NUM_COLS);
    localparam logic [IDX_W-1:0] GMASK    = IDX_W'(GROUP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

    state_e                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   grp_vld_q, grp_vld_d;
    logic [ACC_W-1:0]       grp_sum_q, grp_sum_d;
    logic [COL_W-1:0]       grp_col_q, grp_col_d;
    logic                   grp_log_q, grp_log_d;
    logic                   grp_dec_q, grp_dec_d;
    logic                   disp_sel_q;
    logic [HEIGHT_BITS-1:0] bank_q [2][NUM_COLS];
    logic [HEIGHT_BITS-1:0] rd_q;

    logic                   take_w, last_w, swap_w;
    logic [IDX_W-1:0]       idx_w;
    logic [HEIGHT_BITS-1:0] prev_w, height_w;

    // A sop bin restarts indexing; outside a frame only sop bins are kept.
    assign take_w = source_valid && ready_q && ((state_q == ACCUM) || source_sop);
    assign idx_w  = source_sop ? '0 : cnt_q;
    assign last_w = (idx_w == LAST_IDX);

    always_ff @(posedge MCLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_w) state_d = ACCUM;
            ACCUM:   if (take_w && last_w) state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        swap_w     = (state_q == PUBLISH);
        frame_done = swap_w;
        ready_d    = (state_d != PUBLISH);
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        grp_vld_d = 1'b0;
        grp_sum_d = grp_sum_q;
        grp_col_d = grp_col_q;
        grp_log_d = grp_log_q;
        grp_dec_d = grp_dec_q;
        if (take_w) begin
            cnt_d = idx_w + 1'b1;
            acc_d = (((idx_w & GMASK) == '0) ? '0 : acc_q) + ACC_W'(F_BIN_IN);
            if ((idx_w & GMASK) == GMASK) begin
                grp_vld_d = 1'b1;
                grp_sum_d = acc_d;
                grp_col_d = COL_W'(idx_w >> GSH);
                grp_log_d = log_mode;
                grp_dec_d = decay_en;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            ready_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            grp_vld_q <= 1'b0;
            grp_sum_q <= '0;
            grp_col_q <= '0;
            grp_log_q <= 1'b0;
            grp_dec_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            grp_vld_q <= grp_vld_d;
            grp_sum_q <= grp_sum_d;
            grp_col_q <= grp_col_d;
            grp_log_q <= grp_log_d;
            grp_dec_q <= grp_dec_d;
        end
    end

    assign prev_w = bank_q[disp_sel_q][grp_col_q];

    height_scaler #(
        .BIN_WIDTH  (BIN_WIDTH),
        .MTRX_HEIGHT(MTRX_HEIGHT),
        .HEIGHT_BITS(HEIGHT_BITS),
        .LIN_SHIFT  (LIN_SHIFT)
    ) u_scaler (
        .avg_i     (BIN_WIDTH'(grp_sum_q >> GSH)),
        .log_mode_i(grp_log_q),
        .decay_en_i(grp_dec_q),
        .prev_i    (prev_w),
        .height_o  (height_w)
    );

    // The last group's write and the bank swap share an edge; the write
    // still targets the old write bank and decays against the old display.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            disp_sel_q <= 1'b0;
            rd_q       <= '0;
            bank_q     <= '{default: '0};
        end else begin
            if (grp_vld_q) bank_q[~disp_sel_q][grp_col_q] <= height_w;
            if (swap_w) disp_sel_q <= ~disp_sel_q;
            rd_q <= bank_q[disp_sel_q][rd_col];
        end
    end

    assign sink_ready = ready_q;
    assign rd_height  = rd_q;

endmodule

// File: tb/tb_spectrum_binner.sv
// Self-checking bench for spectrum_binner: directed frame table, multi-cycle
// corner sequences and randomized traffic against a frame-level reference model.
module tb_spectrum_binner;

    localparam int BW = 24;
    localparam int NB = 256;
    localparam int NC = 64;
    localparam int MH = 32;
    localparam int HB = 6;
    localparam int LS = 16;
    localparam int G  = NB / NC;

    logic          MCLK = 1'b0;
    logic          RESET, source_valid, source_sop, log_mode, decay_en;
    logic [BW-1:0] F_BIN_IN;
    logic [5:0]    rd_col;
    logic          sink_ready, frame_done;
    logic [HB-1:0] rd_height;

    always #5 MCLK = ~MCLK;

    spectrum_binner #(
        .BIN_WIDTH  (BW),
        .NUM_BINS   (NB),
        .NUM_COLS   (NC),
        .MTRX_HEIGHT(MH),
        .HEIGHT_BITS(HB),
        .LIN_SHIFT  (LS)
    ) dut (
        .MCLK        (MCLK),
        .RESET       (RESET),
        .source_valid(source_valid),
        .source_sop  (source_sop),
        .F_BIN_IN    (F_BIN_IN),
        .sink_ready  (sink_ready),
        .log_mode    (log_mode),
        .decay_en    (decay_en),
        .rd_col      (rd_col),
        .rd_height   (rd_height),
        .frame_done  (frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: displayed heights, heights built for the next frame,
    // and the bins collected so far in the current frame.
    int disp[NC];
    int wr[NC];
    int fbins[NB];
    int nb = 0;
    bit in_frame = 0;
    bit pub_now = 0;
    int since_rst = -1;
    int exp_rd = 0;
    int fd_seen = 0;
    int rdy_low = 0;

    typedef struct {
        int val;
        bit lm;
        bit de;
        int exp_h;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_h(input int avg, input bit lm, input bit de, input int prev);
        int h;
        if (lm) h = (avg == 0) ? 0 : $clog2(avg + 1);
        else    h = avg >> LS;
        if (h > MH) h = MH;
        if (de && (prev - 1 > h)) h = prev - 1;
        return h;
    endfunction

    // One clock cycle: check this cycle's outputs, drive inputs, advance model.
    task automatic cyc(input bit rst, input bit v, input bit s, input int d,
                       input int col, input bit lm, input bit de, output bit acc);
        bit rdy_m;
        int sum;
        int c;
        if (since_rst == 0) begin
            check("reset_ready", sink_ready, 0);
            check("reset_frame_done", frame_done, 0);
            check("reset_rd_height", rd_height, 0);
        end else if (since_rst > 0) begin
            check("frame_done", frame_done, pub_now);
            if (since_rst > NC + 1) begin
                check("sink_ready", sink_ready, !pub_now);
                check("rd_height", rd_height, exp_rd);
                if (sink_ready === 1'b0) rdy_low++;
            end
        end
        if (frame_done === 1'b1) fd_seen++;

        RESET        = rst;
        source_valid = v;
        source_sop   = s;
        F_BIN_IN     = BW'(d);
        rd_col       = 6'(col);
        log_mode     = lm;
        decay_en     = de;

        rdy_m  = (since_rst > NC) && !pub_now;
        acc    = v && rdy_m && !rst;
        exp_rd = rst ? 0 : disp[col];

        if (rst) begin
            foreach (disp[i]) disp[i] = 0;
            in_frame  = 0;
            pub_now   = 0;
            nb        = 0;
            since_rst = 0;
        end else begin
            if (since_rst >= 0 && since_rst < 100000) since_rst++;
            if (pub_now) begin
                disp    = wr;
                pub_now = 0;
            end
            if (acc) begin
                if (s) begin
                    in_frame = 1;
                    nb       = 0;
                end
                if (in_frame) begin
                    fbins[nb] = d;
                    if (nb % G == G - 1) begin
                        sum = 0;
                        for (int j = nb - G + 1; j <= nb; j++) sum += fbins[j];
                        c = nb / G;
                        wr[c] = ref_h(sum / G, lm, de, disp[c]);
                    end
                    nb++;
                    if (nb == NB) begin
                        in_frame = 0;
                        nb       = 0;
                        pub_now  = 1;
                    end
                end
            end
        end
        @(posedge MCLK);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, i % NC, 0, 0, a);
    endtask

    task automatic send_bins(input int cnt, input int val, input bit lm, input bit de);
        bit a;
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < cnt && guard < cnt + 16) begin
            cyc(0, 1, k == 0, val, guard % NC, lm, de, a);
            if (a) k++;
            guard++;
        end
        if (k < cnt) check("bin_accept_timeout", k, cnt);
    endtask

    task automatic read_expect(input string name, input int exp);
        bit a;
        for (int c = 0; c < NC; c++) begin
            cyc(0, 0, 0, 0, c, 0, 0, a);
            check(name, rd_height, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int fd0;
        int k;
        int guard;
        int val;
        bit rst, v, s, lm, de;
        foreach (disp[i]) begin
            disp[i] = 0;
            wr[i]   = 0;
        end
        RESET = 1'b1; source_valid = 1'b0; source_sop = 1'b0; F_BIN_IN = '0;
        rd_col = '0; log_mode = 1'b0; decay_en = 1'b0;

        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, a);
        idle(NC + 4);
        read_expect("post_reset_height", 0);

        tbl[0]  = '{32'h050000, 1'b0, 1'b0, 5};
        tbl[1]  = '{32'hFFFFFF, 1'b0, 1'b0, 32};
        tbl[2]  = '{32'hFFFFFF, 1'b1, 1'b0, 24};
        tbl[3]  = '{32'h000001, 1'b1, 1'b0, 1};
        tbl[4]  = '{32'h1F0000, 1'b0, 1'b0, 31};
        tbl[5]  = '{32'h000000, 1'b0, 1'b1, 30};
        tbl[6]  = '{32'h000000, 1'b0, 1'b1, 29};
        tbl[7]  = '{32'h000000, 1'b0, 1'b0, 0};
        tbl[8]  = '{32'h210000, 1'b0, 1'b0, 32};
        tbl[9]  = '{32'h00FFFF, 1'b0, 1'b0, 0};
        tbl[10] = '{32'h000100, 1'b1, 1'b0, 9};
        tbl[11] = '{32'h000000, 1'b1, 1'b0, 0};
        tbl[12] = '{32'h1F0000, 1'b0, 1'b1, 31};
        tbl[13] = '{32'h050000, 1'b0, 1'b1, 30};

        for (int t = 0; t < 14; t++) begin
            fd0 = fd_seen;
            send_bins(NB, tbl[t].val, tbl[t].lm, tbl[t].de);
            idle(3);
            check("table_frame_done_count", fd_seen - fd0, 1);
            read_expect("table_height", tbl[t].exp_h);
        end

        // Resync: a new sop after 100 bins needs a full 256 more bins.
        fd0 = fd_seen;
        send_bins(100, 32'h0A0000, 0, 0);
        send_bins(NB, 32'h030000, 0, 0);
        idle(3);
        check("resync_frame_done_count", fd_seen - fd0, 1);
        read_expect("resync_height", 3);

        // Handshake: valid held high across two back-to-back frames.
        rdy_low = 0;
        k = 0;
        guard = 0;
        while (k < 2 * NB && guard < 2 * NB + 20) begin
            val = (((k % NB) / G) % 33) << 16;
            cyc(0, 1, (k % NB) == 0, val, 0, 0, 0, a);
            if (a) k++;
            guard++;
        end
        check("handshake_bins_accepted", k, 2 * NB);
        idle(3);
        check("handshake_ready_low_cycles", rdy_low, 2);
        for (int c = 0; c < NC; c++) begin
            cyc(0, 0, 0, 0, c, 0, 0, a);
            check("handshake_height", rd_height, c % 33);
        end

        // Reset in the middle of a frame abandons it.
        fd0 = fd_seen;
        send_bins(128, 32'h0F0000, 0, 0);
        cyc(1, 1, 0, 32'h0F0000, 0, 0, 0, a);
        cyc(1, 0, 0, 0, 0, 0, 0, a);
        idle(NC + 4);
        check("reset_mid_frame_done_count", fd_seen - fd0, 0);
        read_expect("reset_mid_height", 0);

        // Randomized traffic, modes toggling mid-frame, occasional resync/reset.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 1499) == 0);
            v   = ($urandom_range(0, 3) != 0) && (since_rst > NC + 1);
            s   = in_frame ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) == 0);
            lm  = ($urandom_range(0, 7) == 0) ? ~log_mode : log_mode;
            de  = ($urandom_range(0, 7) == 0) ? ~decay_en : decay_en;
            val = int'($urandom_range(0, 32'hFFFFFF) >> $urandom_range(0, 23));
            cyc(rst, v, s, val, int'($urandom_range(0, NC - 1)), lm, de, a);
        end
        idle(NC + 4);
        read_expect("final_read", disp[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spectrum_binner.md
SPECTRUM_BINNER -- requirements
Module: spectrum_binner

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BIN_WIDTH, 24, width of each FFT magnitude bin.
- NUM_BINS, 256, bins per frame; power of 2.
- NUM_COLS, 64, matrix columns; power of 2; NUM_COLS <= NUM_BINS.
- MTRX_HEIGHT, 32, maximum column height.
- HEIGHT_BITS, 6, width of a height value; must hold MTRX_HEIGHT.
- LIN_SHIFT, 16, right shift from averaged magnitude to linear height.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- MCLK, in, 1, sole clock, rising edge.
- RESET, in, 1, synchronous, active-high.
- source_valid, in, 1, bin qualifier.
- source_sop, in, 1, first bin of frame; meaningful only when source_valid=1.
- F_BIN_IN, in, BIN_WIDTH, bin magnitude.
- sink_ready, out, 1, block accepts bins.
- log_mode, in, 1, 1 = logarithmic height, 0 = linear.
- decay_en, in, 1, peak-hold with fall of one step per frame.
- rd_col, in, log2(NUM_COLS), display read address.
- rd_height, out, HEIGHT_BITS, height of rd_col from the display bank.
- frame_done, out, 1, one-cycle pulse when a new bank is published.

Function
REQ-003 A bin SHALL be accepted only on a cycle where source_valid=1 and sink_ready=1; all other input cycles are ignored.
REQ-004 The FSM SHALL have states IDLE, ACCUM and PUBLISH. IDLE goes to ACCUM on an accepted bin with source_sop=1. ACCUM goes to PUBLISH on the accepted bin with index NUM_BINS-1. PUBLISH returns to IDLE after exactly 1 cycle.
REQ-005 sink_ready SHALL be 1 in IDLE and ACCUM, and 0 in PUBLISH.
REQ-006 In IDLE, accepted bins with source_sop=0 SHALL be discarded.
REQ-007 In ACCUM, an accepted bin with source_sop=1 SHALL restart the frame:
- bin index becomes 0 and the accumulator is loaded with that bin;
- the partial frame's columns remain in the write bank and are overwritten.
REQ-008 GROUP = NUM_BINS/NUM_COLS consecutive bins SHALL be summed in an accumulator of width BIN_WIDTH+log2(GROUP); it cannot overflow.
REQ-009 On the last bin of a group, avg = sum >> log2(GROUP) SHALL be computed, truncated, with no rounding.
REQ-010 Linear height SHALL be min(avg >> LIN_SHIFT, MTRX_HEIGHT).
REQ-011 Log height SHALL be min(index of MSB of avg + 1, MTRX_HEIGHT); avg=0 gives 0.
REQ-012 With decay_en=1, the stored height SHALL be max(new, prev-1 saturating at 0), where prev is that column's value in the display bank. With decay_en=0, stored = new.
REQ-013 Column heights SHALL be written to the write bank at index bin_index/GROUP, at most 2 cycles after the group's last bin is accepted.
REQ-014 Banks SHALL be double-buffered. In PUBLISH, the write bank becomes the display bank and frame_done=1 for that single cycle.
REQ-015 rd_height SHALL be registered, 1-cycle latency from rd_col. A bank swap SHALL take effect on reads issued the cycle after PUBLISH.
REQ-016 log_mode and decay_en SHALL be sampled per group, at group completion; changing them mid-frame is legal.
REQ-017 Column index SHALL wrap to 0 at the start of each frame; the bin index never exceeds NUM_BINS-1.

Reset
REQ-018 While RESET=1 at a rising MCLK edge, the block SHALL reset to:
- state = IDLE, accumulator = 0, bin index = 0;
- frame_done = 0, sink_ready = 0, rd_height = 0;
- both banks cleared to 0 (clearing may take NUM_COLS cycles after release, with sink_ready held 0 meanwhile).
REQ-019 RESET asserted mid-frame SHALL abandon the frame with no frame_done and no bank swap.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding and a clog2 helper; GROUP and the accumulator width are derived locally.
REQ-021 Height conversion (REQ-010 to REQ-012) SHALL be a combinational sub-module, height_scaler.

Verification
REQ-022 Constant bins: 256 bins of 0x050000 with sop on bin 0, linear mode -> all 64 heights = 5; frame_done exactly once, 1 cycle after bin 255 is accepted.
REQ-023 Saturation: 0xFFFFFF bins in linear mode -> height 32; the same in log mode -> 24 clamped to 24 (<=32); a bin of 1 in log mode -> 1.
REQ-024 Decay: frame of 0x1F0000 then a frame of zeros with decay_en=1 -> heights 31 then 30; with decay_en=0 -> 0.
REQ-025 Resync: sop at bin 100 of a frame -> exactly 256 further bins are needed before frame_done; no frame_done at the original bin 255.
REQ-026 Handshake and reset: source_valid held 1 -> sink_ready=0 for exactly the PUBLISH cycle and no bin is lost or duplicated; RESET at bin 128 -> no frame_done, rd_height 0 after clearing.
